cpu_ctrl_fsm: RTL and testbench

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

---
 rtl/cpu_ctrl_if.sv | 35 +++
 rtl/cpu_ctrl_fsm.sv | 133 +++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_if.sv
// Control-unit bus: start/load/instruction in, datapath strobes and selects out.
// Signal suffixes are from the controller's point of view (slave modport).
interface cpu_ctrl_if;
  logic        s_i;
  logic        load_i;
  logic [15:0] in_i;
  logic [2:0]  readnum_o;
  logic [2:0]  writenum_o;
  logic        write_o;
  logic        loada_o;
  logic        loadb_o;
  logic        loadc_o;
  logic        loads_o;
  logic        asel_o;
  logic        bsel_o;
  logic [1:0]  vsel_o;
  logic [1:0]  shift_o;
  logic [1:0]  alu_op_o;
  logic [15:0] sximm8_o;
  logic [15:0] sximm5_o;
  logic        w_o;
  logic        illegal_o;

  modport slave (
    input  s_i, load_i, in_i,
    output readnum_o, writenum_o, write_o, loada_o, loadb_o, loadc_o, loads_o,
           asel_o, bsel_o, vsel_o, shift_o, alu_op_o, sximm8_o, sximm5_o, w_o, illegal_o
  );

  modport master (
    output s_i, load_i, in_i,
    input  readnum_o, writenum_o, write_o, loada_o, loadb_o, loadc_o, loads_o,
           asel_o, bsel_o, vsel_o, shift_o, alu_op_o, sximm8_o, sximm5_o, w_o, illegal_o
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU controller: instruction register plus Moore sequencing FSM.
// Define CPU_CTRL_ILLEGAL_TRAP_EN to trap illegal instructions in HALT until reset.
module cpu_ctrl_fsm (
  input  logic       clk,
  input  logic       rst,
  cpu_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    StWait, StDecode, StGetA, StGetB, StAlu, StWrReg, StWrImm, StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_mov_imm, is_mov_reg, is_mvn, is_add, is_and, is_cmp, is_alu_op;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
  assign is_add     = (opcode == 3'b101) && (op == 2'b00);
  assign is_and     = (opcode == 3'b101) && (op == 2'b10);
  assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);
  assign is_alu_op  = (opcode == 3'b101);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StWait;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // IR only accepts a new word while idle so an in-flight instruction is stable.
  always_comb begin
    ir_d = ir_q;
    if (bus.load_i && (state_q == StWait)) ir_d = bus.in_i;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait:   if (bus.s_i) state_d = StDecode;
      StDecode: begin
        if (is_mov_imm)                   state_d = StWrImm;
        else if (is_mov_reg || is_mvn)    state_d = StGetB;
        else if (is_add || is_and || is_cmp) state_d = StGetA;
        else begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
          state_d = StHalt;
`else
          state_d = StWait;
`endif
        end
      end
      StGetA:   state_d = StGetB;
      StGetB:   state_d = StAlu;
      StAlu:    state_d = is_cmp ? StWait : StWrReg;
      StWrReg:  state_d = StWait;
      StWrImm:  state_d = StWait;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      StHalt:   state_d = StHalt;
`else
      StHalt:   state_d = StWait;
`endif
      default:  state_d = StWait;
    endcase
  end

  always_comb begin
    bus.readnum_o  = 3'd0;
    bus.writenum_o = 3'd0;
    bus.write_o    = 1'b0;
    bus.loada_o    = 1'b0;
    bus.loadb_o    = 1'b0;
    bus.loadc_o    = 1'b0;
    bus.loads_o    = 1'b0;
    bus.asel_o     = 1'b0;
    bus.bsel_o     = 1'b0;
    bus.vsel_o     = 2'b00;
    unique case (state_q)
      StGetA: begin
        bus.loada_o   = 1'b1;
        bus.readnum_o = rn;
      end
      StGetB: begin
        bus.loadb_o   = 1'b1;
        bus.readnum_o = rm;
      end
      StAlu: begin
        bus.loadc_o = 1'b1;
        bus.loads_o = is_cmp;
        // Single-operand ops pass B through with A forced to zero.
        bus.asel_o  = is_mov_reg || is_mvn;
      end
      StWrReg: begin
        bus.write_o    = 1'b1;
        bus.writenum_o = rd;
        bus.vsel_o     = 2'b00;
      end
      StWrImm: begin
        bus.write_o    = 1'b1;
        bus.writenum_o = rn;
        bus.vsel_o     = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.shift_o  = (is_alu_op || is_mov_reg) ? sh : 2'b00;
  assign bus.alu_op_o = is_alu_op ? op : 2'b00;
  assign bus.sximm8_o = {{8{ir_q[7]}}, ir_q[7:0]};
  assign bus.sximm5_o = {{11{ir_q[4]}}, ir_q[4:0]};
  assign bus.w_o      = (state_q == StWait);

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal_o = (state_q == StHalt);
`else
  assign bus.illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm; expected per-cycle outputs are queued when stimulus is
// driven and popped one per cycle. Honours CPU_CTRL_ILLEGAL_TRAP_EN for the illegal case.
module tb_cpu_ctrl_fsm;

  typedef struct packed {
    logic        w;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic        illegal;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  alu_op;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
  } vec_t;

  localparam logic [15:0] IrZero = 16'h0000;
  localparam logic [15:0] IrMov  = 16'hD007;
  localparam logic [15:0] IrAdd  = 16'hA148;
  localparam logic [15:0] IrCmp  = 16'hA801;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t sb[$];

  cpu_ctrl_if bus ();

  cpu_ctrl_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strb = {write, loada, loadb, loadc, loads, asel}
  function automatic vec_t ev(input logic [15:0] ir, input logic [1:0] sh, input logic [1:0] alu,
                              input logic w, input logic [5:0] strb, input logic [1:0] vsel,
                              input logic [2:0] rnum, input logic [2:0] wnum, input logic ill);
    vec_t v;
    v          = '0;
    v.w        = w;
    v.write    = strb[5];
    v.loada    = strb[4];
    v.loadb    = strb[3];
    v.loadc    = strb[2];
    v.loads    = strb[1];
    v.asel     = strb[0];
    v.illegal  = ill;
    v.vsel     = vsel;
    v.shift    = sh;
    v.alu_op   = alu;
    v.readnum  = rnum;
    v.writenum = wnum;
    v.sximm8   = {{8{ir[7]}}, ir[7:0]};
    v.sximm5   = {{11{ir[4]}}, ir[4:0]};
    return v;
  endfunction

  function automatic vec_t observe();
    vec_t v;
    v.w        = bus.w_o;
    v.write    = bus.write_o;
    v.loada    = bus.loada_o;
    v.loadb    = bus.loadb_o;
    v.loadc    = bus.loadc_o;
    v.loads    = bus.loads_o;
    v.asel     = bus.asel_o;
    v.bsel     = bus.bsel_o;
    v.illegal  = bus.illegal_o;
    v.vsel     = bus.vsel_o;
    v.shift    = bus.shift_o;
    v.alu_op   = bus.alu_op_o;
    v.readnum  = bus.readnum_o;
    v.writenum = bus.writenum_o;
    v.sximm8   = bus.sximm8_o;
    v.sximm5   = bus.sximm5_o;
    return v;
  endfunction

  task automatic compare(input string tag);
    vec_t exp_v;
    vec_t obs_v;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, observe());
    end else begin
      exp_v = sb.pop_front();
      obs_v = observe();
      assert (obs_v === exp_v)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
      end
    end
  endtask

  task automatic check_now(input string tag);
    #1;
    compare(tag);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.s_i    = 1'b0;
    bus.load_i = 1'b0;
    bus.in_i   = 16'h0000;

    // Reset state
    sb.push_back(ev(IrZero, 2'b00, 2'b00, 1'b1, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b0));
    check_now("reset_async");
    sb.push_back(ev(IrZero, 2'b00, 2'b00, 1'b1, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b0));
    tick("reset_edge");
    rst = 1'b0;
    sb.push_back(ev(IrZero, 2'b00, 2'b00, 1'b1, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b0));
    tick("idle_after_reset");

    // MOV R0,#7
    bus.load_i = 1'b1; bus.in_i = IrMov; bus.s_i = 1'b1;
    sb.push_back(ev(IrMov, 2'b00, 2'b00, 1'b0, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b0));
    sb.push_back(ev(IrMov, 2'b00, 2'b00, 1'b0, 6'b100000, 2'b10, 3'd0, 3'd0, 1'b0));
    sb.push_back(ev(IrMov, 2'b00, 2'b00, 1'b1, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b0));
    tick("mov_decode");
    bus.load_i = 1'b0; bus.s_i = 1'b0;
    tick("mov_wr_imm");
    tick("mov_done");

    // ADD R2,R1,R0,LSL#1
    bus.load_i = 1'b1; bus.in_i = IrAdd; bus.s_i = 1'b1;
    sb.push_back(ev(IrAdd, 2'b01, 2'b00, 1'b0, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b0));
    sb.push_back(ev(IrAdd, 2'b01, 2'b00, 1'b0, 6'b010000, 2'b00, 3'd1, 3'd0, 1'b0));
    sb.push_back(ev(IrAdd, 2'b01, 2'b00, 1'b0, 6'b001000, 2'b00, 3'd0, 3'd0, 1'b0));
    sb.push_back(ev(IrAdd, 2'b01, 2'b00, 1'b0, 6'b000100, 2'b00, 3'd0, 3'd0, 1'b0));
    sb.push_back(ev(IrAdd, 2'b01, 2'b00, 1'b0, 6'b100000, 2'b00, 3'd0, 3'd2, 1'b0));
    sb.push_back(ev(IrAdd, 2'b01, 2'b00, 1'b1, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b0));
    tick("add_decode");
    bus.load_i = 1'b0; bus.s_i = 1'b0;
    tick("add_get_a");
    tick("add_get_b");
    tick("add_alu");
    tick("add_wr_reg");
    tick("add_done");

    // CMP R0,R1
    bus.load_i = 1'b1; bus.in_i = IrCmp; bus.s_i = 1'b1;
    sb.push_back(ev(IrCmp, 2'b00, 2'b01, 1'b0, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b0));
    sb.push_back(ev(IrCmp, 2'b00, 2'b01, 1'b0, 6'b010000, 2'b00, 3'd0, 3'd0, 1'b0));
    sb.push_back(ev(IrCmp, 2'b00, 2'b01, 1'b0, 6'b001000, 2'b00, 3'd1, 3'd0, 1'b0));
    sb.push_back(ev(IrCmp, 2'b00, 2'b01, 1'b0, 6'b000110, 2'b00, 3'd0, 3'd0, 1'b0));
    sb.push_back(ev(IrCmp, 2'b00, 2'b01, 1'b1, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b0));
    tick("cmp_decode");
    bus.load_i = 1'b0; bus.s_i = 1'b0;
    tick("cmp_get_a");
    tick("cmp_get_b");
    tick("cmp_alu");
    tick("cmp_done");

    // ADD again, with a load attempt while busy and a reset landing in GET_B
    bus.load_i = 1'b1; bus.in_i = IrAdd; bus.s_i = 1'b1;
    sb.push_back(ev(IrAdd, 2'b01, 2'b00, 1'b0, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b0));
    tick("busy_decode");
    bus.s_i = 1'b0; bus.in_i = 16'h00FF;
    sb.push_back(ev(IrAdd, 2'b01, 2'b00, 1'b0, 6'b010000, 2'b00, 3'd1, 3'd0, 1'b0));
    sb.push_back(ev(IrAdd, 2'b01, 2'b00, 1'b0, 6'b001000, 2'b00, 3'd0, 3'd0, 1'b0));
    tick("busy_load_get_a");
    tick("busy_load_get_b");
    rst = 1'b1;
    sb.push_back(ev(IrZero, 2'b00, 2'b00, 1'b1, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b0));
    check_now("reset_in_get_b");
    bus.load_i = 1'b0;
    sb.push_back(ev(IrZero, 2'b00, 2'b00, 1'b1, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b0));
    tick("reset_held");
    rst = 1'b0;

    // Illegal opcode 000, started on the first edge after reset release
    bus.load_i = 1'b1; bus.in_i = IrZero; bus.s_i = 1'b1;
    sb.push_back(ev(IrZero, 2'b00, 2'b00, 1'b0, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b0));
    tick("illegal_decode");
    bus.load_i = 1'b0; bus.s_i = 1'b0;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ev(IrZero, 2'b00, 2'b00, 1'b0, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b1));
      tick("illegal_halt");
      bus.s_i = 1'b1;
    end
    rst = 1'b1;
    sb.push_back(ev(IrZero, 2'b00, 2'b00, 1'b1, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b0));
    check_now("halt_reset");
    bus.s_i = 1'b0;
    sb.push_back(ev(IrZero, 2'b00, 2'b00, 1'b1, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b0));
    tick("halt_reset_edge");
    rst = 1'b0;
`else
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ev(IrZero, 2'b00, 2'b00, 1'b1, 6'b000000, 2'b00, 3'd0, 3'd0, 1'b0));
      tick("illegal_to_wait");
    end
`endif

    // Leftover expectations mean a step was never compared
    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
